// File: rtl/vendor_pkg.sv
// Shared vending definitions: coin codes, coin value table and the dispenser state encoding.
package vendor_pkg;

  localparam int NUM_COINS = 4;

  localparam logic [1:0] COIN_10  = 2'd0;
  localparam logic [1:0] COIN_20  = 2'd1;
  localparam logic [1:0] COIN_50  = 2'd2;
  localparam logic [1:0] COIN_100 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    DONE,
    FAULT
  } state_t;

  function automatic logic [8:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_10:  coin_value = 9'd10;
      COIN_20:  coin_value = 9'd20;
      COIN_50:  coin_value = 9'd50;
      default:  coin_value = 9'd100;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest available denomination not exceeding the remaining balance.
module coin_select
  import vendor_pkg::*;
(
  input  logic [8:0] remaining,
  input  logic [3:0] avail,
  output logic       sel_valid,
  output logic [1:0] sel_coin
);

  // Ascending scan, so the last match is the largest eligible coin.
  always_comb begin
    sel_valid = 1'b0;
    sel_coin  = COIN_10;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (avail[i] && coin_value(2'(i)) <= remaining) begin
        sel_valid = 1'b1;
        sel_coin  = 2'(i);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Refund payout controller driving a coin hopper handshake with per-coin timeout.
// Define CHANGE_INVENTORY_EN to track per-denomination stock with restock input.
module change_dispenser
  import vendor_pkg::*;
#(
  parameter int INV_W         = 8,
  parameter int INIT_COUNT    = 16,
  parameter int EJECT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refund_req,
  input  logic [8:0] refund_amount,
  input  logic       eject_done,
  input  logic       restock_valid,
  input  logic [1:0] restock_coin,
  output logic       eject_valid,
  output logic [1:0] eject_coin,
  output logic       busy,
  output logic       refund_done,
  output logic       refund_short,
  output logic       fault,
  output logic [8:0] remaining
);

  localparam int TW = $clog2(EJECT_TIMEOUT + 1);

  state_t        state, state_nxt;
  logic [1:0]    cur_coin;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    avail;
  logic          sel_valid;
  logic [1:0]    sel_coin;
  logic          take;

  assign take = (state == EJECT) && eject_done;

  coin_select u_sel (
    .remaining (remaining),
    .avail     (avail),
    .sel_valid (sel_valid),
    .sel_coin  (sel_coin)
  );

`ifdef CHANGE_INVENTORY_EN
  logic [INV_W-1:0] stock [NUM_COINS];

  // Restock and eject of the same coin in one cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_COINS; i++) stock[i] <= INV_W'(INIT_COUNT);
    end else begin
      for (int i = 0; i < NUM_COINS; i++) begin
        if (restock_valid && restock_coin == 2'(i) && !(take && cur_coin == 2'(i))) begin
          if (stock[i] != '1) stock[i] <= stock[i] + 1'b1;
        end else if (take && cur_coin == 2'(i) &&
                     !(restock_valid && restock_coin == 2'(i))) begin
          stock[i] <= stock[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    avail = '0;
    for (int i = 0; i < NUM_COINS; i++) avail[i] = (stock[i] != '0);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{restock_valid, restock_coin, INV_W[0], INIT_COUNT[0]};
  assign avail      = '1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (refund_req) state_nxt = SELECT;
      SELECT: if (remaining != '0 && sel_valid) state_nxt = EJECT;
              else state_nxt = DONE;
      EJECT:  if (eject_done) state_nxt = SELECT;
              else if (tmo_cnt == TW'(EJECT_TIMEOUT - 1)) state_nxt = FAULT;
      DONE:   state_nxt = IDLE;
      FAULT:  state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining    <= '0;
      cur_coin     <= COIN_10;
      refund_short <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (refund_req) begin
          remaining    <= refund_amount;
          refund_short <= 1'b0;
        end
        SELECT: begin
          cur_coin <= sel_coin;
          tmo_cnt  <= '0;
          if (remaining != '0 && !sel_valid) refund_short <= 1'b1;
        end
        EJECT: begin
          if (eject_done) remaining <= remaining - coin_value(cur_coin);
          else            tmo_cnt   <= tmo_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign eject_valid = (state == EJECT);
  assign eject_coin  = eject_valid ? cur_coin : COIN_10;
  assign busy        = (state != IDLE);
  assign refund_done = (state == DONE);
  assign fault       = (state == FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy payout model.
module tb_change_dispenser;

`ifdef CHANGE_INVENTORY_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, refund_req, eject_done, restock_valid;
  logic [8:0] refund_amount;
  logic [1:0] restock_coin;
  logic       eject_valid, busy, refund_done, refund_short, fault;
  logic [1:0] eject_coin;
  logic [8:0] remaining;

  int checks = 0;
  int errors = 0;
  int m_stock [4];
  int val [4] = '{10, 20, 50, 100};

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk           (clk),
    .reset         (reset),
    .refund_req    (refund_req),
    .refund_amount (refund_amount),
    .eject_done    (eject_done),
    .restock_valid (restock_valid),
    .restock_coin  (restock_coin),
    .eject_valid   (eject_valid),
    .eject_coin    (eject_coin),
    .busy          (busy),
    .refund_done   (refund_done),
    .refund_short  (refund_short),
    .fault         (fault),
    .remaining     (remaining)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_stock[i] = 16;
  endtask

  task automatic do_restock(input int coin);
    restock_valid = 1'b1;
    restock_coin  = 2'(coin);
    tick();
    restock_valid = 1'b0;
    if (INV && m_stock[coin] < 255) m_stock[coin]++;
  endtask

  // Plan the payout greedily from the model stock, then walk the handshake.
  task automatic do_refund(input int amt, input int lat, input bit poke);
    int q[$];
    int rem;
    bit found;
    bit short_e;
    rem   = amt;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int i = 3; i >= 0 && !found; i--) begin
        if (val[i] <= rem && (!INV || m_stock[i] > 0)) begin
          q.push_back(i);
          rem -= val[i];
          if (INV) m_stock[i]--;
          found = 1'b1;
        end
      end
    end
    short_e = (rem != 0);

    refund_req    = 1'b1;
    refund_amount = 9'(amt);
    tick();
    refund_req = 1'b0;
    chk("sel_busy", busy, 1);
    chk("sel_noeject", eject_valid, 0);
    foreach (q[k]) begin
      eject_done = 1'($urandom_range(0, 1));
      tick();
      eject_done = 1'b0;
      chk("ej_valid", eject_valid, 1);
      chk("ej_coin", eject_coin, q[k]);
      if (poke && k == 0) begin
        refund_req    = 1'b1;
        refund_amount = 9'd10;
      end
      for (int w = 0; w < lat; w++) begin
        tick();
        refund_req = 1'b0;
        chk("ej_hold", {eject_valid, eject_coin}, {1'b1, 2'(q[k])});
      end
      eject_done = 1'b1;
      tick();
      eject_done = 1'b0;
      refund_req = 1'b0;
      chk("ej_drop", eject_valid, 0);
    end
    tick();
    chk("done_pulse", refund_done, 1);
    chk("done_short", refund_short, short_e);
    chk("done_rem", remaining, rem);
    tick();
    chk("done_once", refund_done, 0);
    chk("idle_busy", busy, 0);
    chk("short_hold", refund_short, short_e);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; refund_req = 1'b0; refund_amount = '0; eject_done = 1'b0;
    restock_valid = 1'b0; restock_coin = '0;
    tick();
    tick();
    chk("rst_valid", eject_valid, 0);
    chk("rst_coin", eject_coin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", refund_done, 0);
    chk("rst_short", refund_short, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rem", remaining, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_stock[i] = 16;
`ifdef CHANGE_INVENTORY_EN
    for (int i = 0; i < 4; i++) chk("rst_stock", dut.stock[i], 16);
`endif

    do_refund(180, 0, 1'b0);
    do_refund(35, 1, 1'b0);
    do_refund(0, 0, 1'b0);
    do_refund(60, 2, 1'b1);

`ifdef CHANGE_INVENTORY_EN
    apply_reset();
    for (int r = 0; r < 4; r++) do_refund(400, 0, 1'b0);
    chk("stock100", dut.stock[3], m_stock[3]);
    do_refund(200, 0, 1'b0);
    chk("stock50", dut.stock[2], m_stock[2]);
    for (int r = 0; r < 250; r++) do_restock(0);
    chk("stock_sat", dut.stock[0], m_stock[0]);
`endif

    apply_reset();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) do_restock(int'($urandom_range(0, 3)));
      do_refund(int'($urandom_range(0, 511)), int'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0);
    end

    // Reset during the second coin of a 60 refund.
    apply_reset();
    refund_req = 1'b1; refund_amount = 9'd60;
    tick();
    refund_req = 1'b0;
    tick();
    chk("mid_first", eject_coin, 2);
    eject_done = 1'b1;
    tick();
    eject_done = 1'b0;
    tick();
    chk("mid_second", {eject_valid, eject_coin}, 3'b100);
    #2 reset = 1'b1;
    #1;
    chk("mid_valid", eject_valid, 0);
    chk("mid_coin", eject_coin, 0);
    chk("mid_busy", busy, 0);
    chk("mid_rem", remaining, 0);
    chk("mid_done", refund_done, 0);
`ifdef CHANGE_INVENTORY_EN
    chk("mid_stock", dut.stock[2], 16);
`endif
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_stock[i] = 16;

    // Hopper never acknowledges.
    refund_req = 1'b1; refund_amount = 9'd10;
    tick();
    refund_req = 1'b0;
    tick();
    chk("tmo_start", eject_valid, 1);
    for (int c = 0; c < 254; c++) tick();
    chk("tmo_pre", {fault, eject_valid}, 2'b01);
    tick();
    chk("tmo_fault", fault, 1);
    chk("tmo_novalid", eject_valid, 0);
    chk("tmo_busy", busy, 1);
    refund_req = 1'b1; refund_amount = 9'd20;
    tick();
    refund_req = 1'b0;
    tick();
    tick();
    chk("flt_sticky", {fault, eject_valid, refund_done}, 3'b100);
    apply_reset();
    chk("flt_clear", fault, 0);
    do_refund(20, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
